mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one unified, variable-latency memory port between instruction fetch (F stage) and data access (M stage) of the 5-stage MIPS pipeline.
- Sequences one outstanding memory transaction at a time and holds returned data until the requesting stage advances.
- Generates stall requests that top level ORs with the hazard unit's StallF/StallD and uses to freeze E/M/W.

Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- InstReqF  in  1  F stage wants an instruction
- PCF  in  AW  fetch address
- HazStallF  in  1  hazard-unit StallF (F stage frozen by lw/branch stall)
- InstrF  out  DW  fetched instruction (held)
- StallFetch  out  1  fetch not yet complete; stall F and D, flush E
- MemReadM  in  1  M stage load
- MemWriteM  in  1  M stage store
- ALUOutM  in  AW  data address
- WriteDataM  in  DW  store data
- ReadDataM  out  DW  load data (held)
- StallPipe  out  1  data access not complete; freeze F, D, E, M, W
- mem_req  out  1  memory request, level, held until mem_ready
- mem_we  out  1  1 = write
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid with mem_ready
- mem_ready  in  1  one-cycle completion pulse

Behaviour:
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, InstrF=0, ReadDataM=0, i_done=0, d_done=0. StallFetch and StallPipe are forced to 0 while reset=1.
- Decoded signals:
  - d_pend = (MemReadM|MemWriteM) & ~d_done
  - i_pend = InstReqF & ~i_done
- Stall outputs (combinational): StallPipe = d_pend; StallFetch = i_pend.
- FSM, states IDLE, BUSY_D, BUSY_I:
  - IDLE: if d_pend, go to BUSY_D and register mem_req=1, mem_we=MemWriteM, mem_addr=ALUOutM, mem_wdata=WriteDataM. Else if i_pend, go to BUSY_I and register mem_req=1, mem_we=0, mem_addr=PCF. Else stay.
  - Data has priority over fetch: it is the older instruction.
  - BUSY_D: on mem_ready, if it was a read, ReadDataM<=mem_rdata; d_done<=1, mem_req<=0, go to IDLE. Writes leave ReadDataM unchanged.
  - BUSY_I: on mem_ready, InstrF<=mem_rdata, i_done<=1, mem_req<=0, go to IDLE.
- Non-preemptive: a data request arriving during BUSY_I waits for that fetch to complete.
- Latency: request visible at cycle t gives mem_req high at t+1. With memory latency L (mem_ready at t+L), the stall deasserts at t+L+1 and the stage advances at that edge.
- Done clearing:
  - d_done<=0 in any cycle with d_done=1 (M stage consumes, StallPipe=0).
  - i_done<=0 when i_done=1 & ~HazStallF & ~StallPipe (F stage advances).
  - Set and clear of the same flag cannot coincide, because set occurs only in BUSY states while done=0.
- Address/data inputs are sampled only at issue. Their later changes are ignored until the next issue.
- mem_ready in IDLE is ignored.
- Reset mid-transaction: return to IDLE and drop mem_req the next cycle. Any stale mem_ready is ignored, and the memory model must tolerate the abandoned request.
- InstReqF deasserted while BUSY_I: the fetch still completes and InstrF updates. i_done sets but only matters if InstReqF reasserts.
- Back-to-back load after load: d_done clears one cycle after it is set, so the next M-stage request issues at the earliest 2 cycles after the previous mem_ready.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_BUSY_D=2'd1, ST_BUSY_I=2'd2
  - default AW/DW
- Single module, no sub-module. The memory latency model is testbench-only.

Test Plan:
- Fetch only, memory latency 3, PCF=0x0040_0000, rdata=0x2008_0005: mem_req high cycles 1-3, StallFetch high cycles 0-3, InstrF=0x2008_0005 from cycle 4, mem_we=0.
- Load and fetch requested same cycle, ALUOutM=0x1000_0010: data issues first (mem_addr=0x1000_0010, StallPipe high), fetch issues in the cycle after d_done sets, and StallFetch stays high throughout.
- Store mid-fetch: MemWriteM rises during BUSY_I. Fetch completes, then mem_we=1 with mem_wdata=WriteDataM=0xDEAD_BEEF. ReadDataM is unchanged, StallPipe falls one cycle after that mem_ready.
- HazStallF=1 while i_done=1: i_done holds, InstrF holds, and no new fetch issues until HazStallF=0 for one cycle.
- Reset asserted in BUSY_D after 1 cycle: next cycle state=IDLE, mem_req=0, all outputs 0. A subsequent mem_ready pulse causes no state or data change.
- mem_ready pulse while IDLE with no requests: no output change.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared state encoding and default widths for the unified memory-port arbiter.
package mem_arb_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_D = 2'd1,
        ST_BUSY_I = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between F-stage fetch and M-stage data access,
// one outstanding transaction at a time, holding returned data until the stage advances.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          InstReqF,
    input  logic [AW-1:0] PCF,
    input  logic          HazStallF,
    output logic [DW-1:0] InstrF,
    output logic          StallFetch,
    input  logic          MemReadM,
    input  logic          MemWriteM,
    input  logic [AW-1:0] ALUOutM,
    input  logic [DW-1:0] WriteDataM,
    output logic [DW-1:0] ReadDataM,
    output logic          StallPipe,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    arb_state_e    state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] instr_q, instr_d;
    logic [DW-1:0] read_data_q, read_data_d;
    logic          i_done_q, i_done_d;
    logic          d_done_q, d_done_d;
    logic          d_pend_s;
    logic          i_pend_s;

    // Outstanding work per stage; the stalls are held low while reset is asserted
    always_comb begin
        d_pend_s = (MemReadM | MemWriteM) & ~d_done_q;
        i_pend_s = InstReqF & ~i_done_q;
        if (reset) begin
            StallPipe  = 1'b0;
            StallFetch = 1'b0;
        end else begin
            StallPipe  = d_pend_s;
            StallFetch = i_pend_s;
        end
    end

    // Next-state and next-output computation for the transaction sequencer
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        instr_d     = instr_q;
        read_data_d = read_data_q;

        // A done flag lives for exactly the cycle in which its stage consumes the result
        if (d_done_q) begin
            d_done_d = 1'b0;
        end else begin
            d_done_d = d_done_q;
        end
        if (i_done_q & ~HazStallF & ~d_pend_s) begin
            i_done_d = 1'b0;
        end else begin
            i_done_d = i_done_q;
        end

        case (state_q)
            ST_IDLE: begin
                // Data wins over fetch: the M-stage instruction is older
                if (d_pend_s) begin
                    state_d     = ST_BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = MemWriteM;
                    mem_addr_d  = ALUOutM;
                    mem_wdata_d = WriteDataM;
                end else if (i_pend_s) begin
                    state_d    = ST_BUSY_I;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = PCF;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY_D: begin
                if (mem_ready) begin
                    if (!mem_we_q) begin
                        read_data_d = mem_rdata;
                    end else begin
                        read_data_d = read_data_q;
                    end
                    d_done_d  = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_BUSY_D;
                end
            end
            ST_BUSY_I: begin
                if (mem_ready) begin
                    instr_d   = mem_rdata;
                    i_done_d  = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_BUSY_I;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            instr_q     <= '0;
            read_data_q <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            instr_q     <= instr_d;
            read_data_q <= read_data_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign InstrF    = instr_q;
    assign ReadDataM = read_data_q;

endmodule
